// File: rtl/pipelined_carry_skip_adder_pkg.sv
// Shared types and derived-size helpers for the pipelined
// carry-skip adder/subtractor.
package pipelined_carry_skip_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calc_nblk(
    input int width,
    input int block
  );
    return width / block;
  endfunction

  function automatic int calc_lat(
    input int width,
    input int block,
    input int bps
  );
    return (width / block) / bps;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int block,
    input int bps
  );
    return ((width % block) == 0) &&
           (((width / block) % bps) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_skip_adder_block.sv
// One carry-skip block: ripple sum plus a skip mux that
// bypasses the ripple when every bit propagates.
module carry_skip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic             rip;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    rip  = cin;
    sum  = '0;
    cmsb = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i] = p[i] ^ rip;
      cmsb   = rip;
      rip    = g[i] | (p[i] & rip);
    end
    // skip path: block carry comes straight from cin
    cout = (&p) ? cin : rip;
  end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip add/sub with operand skew registers
// and a global-stall valid/ready handshake.
module pipelined_carry_skip_adder
  import pipelined_carry_skip_adder_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int BPS  = BLOCKS_PER_STAGE;
  localparam int NBLK = calc_nblk(WIDTH, BLOCK);
  localparam int LAT  = calc_lat(WIDTH, BLOCK, BPS);
  localparam int SW   = BPS * BLOCK;

  if (!cfg_ok(WIDTH, BLOCK, BPS)) begin : g_bad_cfg
    $error("bad cfg: WIDTH=%0d BLOCK=%0d NBLK=%0d BPS=%0d",
           WIDTH, BLOCK, NBLK, BPS);
  end

  op_e              op;
  logic             adv;
  logic             cin0;
  logic [WIDTH-1:0] b_in;

  assign op      = op_e'(i_sub);
  assign adv     = i_ready | ~o_valid;
  assign o_ready = adv;
  assign cin0    = (op == OP_SUB) ? 1'b1 : i_cin;
  assign b_in    = (op == OP_SUB) ? ~i_add2 : i_add2;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [SW-1:0] ssum;
    logic          scin;
    logic          vin;
    logic [HI-1:0] sum_d;
    logic [HI-1:0] sum_q;
    logic          carry_q;
    logic          valid_q;

    if (k == 0) begin : g_in
      assign sa    = i_add1[SW-1:0];
      assign sb    = b_in[SW-1:0];
      assign scin  = cin0;
      assign vin   = i_valid;
      assign sum_d = ssum;
    end else begin : g_in
      assign sa    = g_stage[k-1].g_skew.a_q[SW-1:0];
      assign sb    = g_stage[k-1].g_skew.b_q[SW-1:0];
      assign scin  = g_stage[k-1].carry_q;
      assign vin   = g_stage[k-1].valid_q;
      assign sum_d = {ssum, g_stage[k-1].sum_q};
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic ci;
      logic co;
      logic cm;
      logic unused_cm;

      if (j == 0) begin : g_ci
        assign ci = scin;
      end else begin : g_ci
        assign ci = g_blk[j-1].co;
      end

      carry_skip_block #(
        .BLOCK(BLOCK)
      ) u_blk (
        .a   (sa[j*BLOCK +: BLOCK]),
        .b   (sb[j*BLOCK +: BLOCK]),
        .cin (ci),
        .sum (ssum[j*BLOCK +: BLOCK]),
        .cout(co),
        .cmsb(cm)
      );

      assign unused_cm = cm;
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        valid_q <= vin;
        sum_q   <= sum_d;
        carry_q <= g_blk[BPS-1].co;
      end
    end

    // operand bits not yet consumed ride along
    if (k < LAT - 1) begin : g_skew
      logic [WIDTH-HI-1:0] a_d;
      logic [WIDTH-HI-1:0] b_d;
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = i_add1[WIDTH-1:HI];
        assign b_d = b_in[WIDTH-1:HI];
      end else begin : g_src
        assign a_d =
          g_stage[k-1].g_skew.a_q[WIDTH-LO-1:SW];
        assign b_d =
          g_stage[k-1].g_skew.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == LAT - 1) begin : g_msb
      logic cmsb_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          cmsb_q <= 1'b0;
        end else if (adv) begin
          cmsb_q <= g_blk[BPS-1].cm;
        end
      end
    end
  end

  assign o_valid    = g_stage[LAT-1].valid_q;
  assign o_result   = g_stage[LAT-1].sum_q;
  assign o_cout     = g_stage[LAT-1].carry_q;
  assign o_overflow = g_stage[LAT-1].g_msb.cmsb_q
                    ^ g_stage[LAT-1].carry_q;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Bench: vector table, random streams, backpressure and
// reset cases against a plain-arithmetic reference model.
module tb_pipelined_carry_skip_adder;

  localparam int LAT = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] add1 = '0;
  logic [31:0] add2 = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] result;
  logic        cout;
  logic        ovf;

  logic        n_valid = 1'b0;
  logic        n_ready;
  logic [15:0] n_add1 = '0;
  logic [15:0] n_add2 = '0;
  logic        n_o_valid;
  logic [15:0] n_result;
  logic        n_cout;
  logic        n_ovf;

  int nchk = 0;
  int nfail = 0;
  int emit_cnt = 0;
  exp_t exp_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  pipelined_carry_skip_adder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_add1    (add1),
    .i_add2    (add2),
    .i_cin     (cin),
    .i_sub     (sub),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (result),
    .o_cout    (cout),
    .o_overflow(ovf)
  );

  pipelined_carry_skip_adder #(
    .WIDTH           (16),
    .BLOCK           (4),
    .BLOCKS_PER_STAGE(1)
  ) dut16 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (n_valid),
    .o_ready   (n_ready),
    .i_add1    (n_add1),
    .i_add2    (n_add2),
    .i_cin     (1'b0),
    .i_sub     (1'b0),
    .o_valid   (n_o_valid),
    .i_ready   (1'b1),
    .o_result  (n_result),
    .o_cout    (n_cout),
    .o_overflow(n_ovf)
  );

  function automatic exp_t model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        c,
    input logic        s
  );
    exp_t   r;
    longint sa;
    longint sb;
    longint sv;
    logic [32:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r.res  = a - b;
      r.cout = (a >= b);
      sv     = sa - sb;
    end else begin
      t      = {1'b0, a} + {1'b0, b} + {32'd0, c};
      r.res  = t[31:0];
      r.cout = t[32];
      sv     = sa + sb + longint'(c);
    end
    r.ovf = (sv > 64'sh7FFFFFFF) ||
            (sv < -64'sh80000000);
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    add1 = $urandom;
    add2 = ($urandom_range(0, 3) == 0) ? ~add1 : $urandom;
    cin  = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    add1  = v.a;
    add2  = v.b;
    cin   = v.cin;
    sub   = v.sub;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (LAT - 2) step();
    chk({nm, "_early"}, 32'(o_valid), 32'd0);
    step();
    chk({nm, "_valid"}, 32'(o_valid), 32'd1);
    chk({nm, "_res"}, result, v.res);
    chk({nm, "_cout"}, 32'(cout), 32'(v.cout));
    chk({nm, "_ovf"}, 32'(ovf), 32'(v.ovf));
    step();
  endtask

  // scoreboard and handshake checker
  logic        have_prev = 1'b0;
  logic [33:0] prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      chk("ready_rule", 32'(ready),
          32'(i_ready || !o_valid));
      if (o_valid && !i_ready) begin
        if (have_prev)
          chk("stall_hold", 32'({result, cout, ovf}),
              32'(prev));
        prev      = {result, cout, ovf};
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (o_valid && i_ready) begin
        emit_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_emit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_res", result, e.res);
          chk("sb_flags", 32'({cout, ovf}),
              32'({e.cout, e.ovf}));
        end
      end
      if (valid && ready)
        exp_q.push_back(model(add1, add2, cin, sub));
    end
  end

  initial begin
    vec_t v;
    int   base;
    int   sent;
    int   cyc;
    logic need_new;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'd5, 32'd7, 1'b1, 1'b0,
                32'd13, 1'b0, 1'b0};
    vecs[4] = '{32'd0, 32'd1, 1'b0, 1'b1,
                32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'd0, 1'b1, 1'b0,
                32'h1234_5679, 1'b0, 1'b0};
    vecs[6] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1,
                32'd0, 1'b1, 1'b0};
    vecs[7] = '{32'd10, 32'd3, 1'b1, 1'b1,
                32'd7, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                32'd0, 1'b1, 1'b1};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
                32'hFFFF_FFFF, 1'b1, 1'b0};

    repeat (2) step();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_out", 32'({result, cout, ovf}), 32'd0);
    chk("rst16_out", 32'({n_o_valid, n_result,
                          n_cout, n_ovf}), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // back-to-back random stream
    base = emit_cnt;
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        drive_rand();
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      step();
      chk("stream_valid", 32'(o_valid),
          32'((c + 1 >= LAT) && (c + 1 < 16 + LAT)));
    end
    chk("stream_count", emit_cnt - base, 32'd16);

    // backpressure: consumer stalls cycles 5..9
    base     = emit_cnt;
    sent     = 0;
    cyc      = 0;
    need_new = 1'b1;
    while ((emit_cnt - base < 8) && cyc < 80) begin
      i_ready = !(cyc >= 5 && cyc <= 9);
      if (sent < 8) begin
        if (need_new) drive_rand();
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 5 && cyc <= 9)
        chk("bp_ready_low", 32'(ready), 32'd0);
      need_new = valid && ready;
      if (need_new) sent++;
      step();
      cyc++;
    end
    i_ready = 1'b1;
    valid   = 1'b0;
    chk("bp_count", emit_cnt - base, 32'd8);
    chk("bp_sent", sent, 32'd8);
    chk("bp_drained", 32'(o_valid), 32'd0);

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      valid = 1'b1;
      step();
    end
    valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_out", 32'({result, cout, ovf}), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    run_vec(vecs[3], "post_rst");
    repeat (LAT) step();
    chk("post_rst_idle", 32'(o_valid), 32'd0);

    // 16-bit instance, one block per stage
    n_add1  = 16'h7FFF;
    n_add2  = 16'h0001;
    n_valid = 1'b1;
    step();
    n_valid = 1'b0;
    repeat (LAT - 2) step();
    chk("w16_early", 32'(n_o_valid), 32'd0);
    step();
    chk("w16_valid", 32'(n_o_valid), 32'd1);
    chk("w16_res", 32'(n_result), 32'h8000);
    chk("w16_ovf", 32'(n_ovf), 32'd1);
    chk("w16_cout", 32'(n_cout), 32'd0);
    n_add1  = 16'hFFFF;
    n_add2  = 16'h0001;
    n_valid = 1'b1;
    step();
    n_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("w16b_res", 32'({n_o_valid, n_result}),
        32'h1_0000);
    chk("w16b_flags", 32'({n_cout, n_ovf}), 32'b10);
    step();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
